// File: rtl/rf_pkg.sv
// Shared constants and address-decode helper for the scoreboarded register file.
package rf_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 4;

  localparam int RESET_ZERO  = 0;
  localparam int RESET_INDEX = 1;

  // Bit r of the one-hot decode of addr; callers sweep r over 0..NUM_REGS-1.
  function automatic logic decode_hit(input logic [31:0] addr, input int r);
    return addr == 32'(r);
  endfunction

endpackage

// File: rtl/rf_bypass_mux.sv
// One read port: forwards same-cycle writes ahead of the stored array row.
module rf_bypass_mux
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NUM_REGS = 16
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic [DATA_W-1:0] row,
  output logic [DATA_W-1:0] rd_data
);

  // An out-of-range index reads zero even if a write port names the same index.
  always_comb begin
    rd_data = '0;
    if (32'(rd_addr) < 32'(NUM_REGS)) begin
      if (wr0_en && (wr0_addr == rd_addr))
        rd_data = wr0_data;
      else if (wr1_en && (wr1_addr == rd_addr))
        rd_data = wr1_data;
      else
        rd_data = row;
    end
  end

endmodule

// File: rtl/rf_scoreboard.sv
// Register file with bypassed read ports, two prioritised write ports and a
// per-register pending scoreboard that drives the pipeline stall request.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int NUM_REGS   = 16,
  parameter int NUM_RD     = 3,
  parameter int RESET_MODE = RESET_INDEX
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_used,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_dest,
  input  logic                     flush,
  output logic                     hazard,
  output logic [NUM_REGS-1:0]      pending
);

  logic [DATA_W-1:0]              regs [NUM_REGS];
  logic [NUM_RD-1:0][DATA_W-1:0]  row;
  logic [NUM_RD-1:0][NUM_REGS-1:0] rd_dec;
  logic [NUM_REGS-1:0]            clr;
  logic [NUM_REGS-1:0]            issue_dec;
  logic [NUM_REGS-1:0]            set;
  logic                           raw;
  logic                           waw;

  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      row[k]    = '0;
      rd_dec[k] = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (decode_hit(32'(rd_addr[k*ADDR_W +: ADDR_W]), r)) begin
          row[k]       = regs[r];
          rd_dec[k][r] = 1'b1;
        end
      end
    end
  end

  // A register being written this cycle is no longer a hazard source.
  always_comb begin
    clr       = '0;
    issue_dec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      clr[r]       = (wr0_en && decode_hit(32'(wr0_addr), r)) ||
                     (wr1_en && decode_hit(32'(wr1_addr), r));
      issue_dec[r] = decode_hit(32'(issue_dest), r);
    end

    raw = 1'b0;
    for (int k = 0; k < NUM_RD; k++)
      raw = raw | (rd_used[k] && |(rd_dec[k] & pending & ~clr));
    waw    = issue_en && |(issue_dec & pending & ~clr);
    hazard = raw | waw;
    set    = (issue_en && !hazard) ? issue_dec : '0;
  end

  // Clear-then-set ordering lets a new producer keep ownership of its register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs[r] <= (RESET_MODE == RESET_INDEX) ? DATA_W'(r) : '0;
      pending <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr0_en && decode_hit(32'(wr0_addr), r))
          regs[r] <= wr0_data;
        else if (wr1_en && decode_hit(32'(wr1_addr), r))
          regs[r] <= wr1_data;
      end
      pending <= flush ? '0 : ((pending & ~clr) | set);
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_bypass_mux #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
    ) u_mux (
      .rd_addr  (rd_addr[k*ADDR_W +: ADDR_W]),
      .wr0_en   (wr0_en),
      .wr0_addr (wr0_addr),
      .wr0_data (wr0_data),
      .wr1_en   (wr1_en),
      .wr1_addr (wr1_addr),
      .wr1_data (wr1_data),
      .row      (row[k]),
      .rd_data  (rd_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed and randomized checks of rf_scoreboard against an array-based model.
module tb_rf_scoreboard;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 16;
  localparam int NP = 3;

  logic           clk;
  logic           rst;
  logic [NP*AW-1:0] rd_addr;
  logic [NP-1:0]  rd_used;
  logic [NP*DW-1:0] rd_data;
  logic           wr0_en, wr1_en, issue_en, flush;
  logic [AW-1:0]  wr0_addr, wr1_addr, issue_dest;
  logic [DW-1:0]  wr0_data, wr1_data;
  logic           hazard;
  logic [NR-1:0]  pending;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_regs [NR];
  bit            m_pend [NR];

  rf_scoreboard #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .NUM_RD(NP), .RESET_MODE(1)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_used(rd_used), .rd_data(rd_data),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .issue_en(issue_en), .issue_dest(issue_dest), .flush(flush),
    .hazard(hazard), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_written(input int a);
    return (wr0_en && int'(wr0_addr) == a) || (wr1_en && int'(wr1_addr) == a);
  endfunction

  function automatic logic [DW-1:0] m_read(input int a);
    if (a >= NR) return '0;
    if (wr0_en && int'(wr0_addr) == a) return wr0_data;
    if (wr1_en && int'(wr1_addr) == a) return wr1_data;
    return m_regs[a];
  endfunction

  function automatic bit m_hazard();
    bit h = 0;
    for (int k = 0; k < NP; k++) begin
      int a = int'(rd_addr[k*AW +: AW]);
      if (rd_used[k] && a < NR && m_pend[a] && !m_written(a)) h = 1;
    end
    if (issue_en && int'(issue_dest) < NR && m_pend[int'(issue_dest)] &&
        !m_written(int'(issue_dest))) h = 1;
    return h;
  endfunction

  function automatic logic [NR-1:0] m_pend_vec();
    logic [NR-1:0] v = '0;
    for (int r = 0; r < NR; r++) v[r] = m_pend[r];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_regs[r] = DW'(r);
      m_pend[r] = 0;
    end
  endtask

  // Apply the current inputs to the model, then let the clock edge pass.
  task automatic tick();
    bit h = m_hazard();
    if (wr1_en && int'(wr1_addr) < NR) m_regs[int'(wr1_addr)] = wr1_data;
    if (wr0_en && int'(wr0_addr) < NR) m_regs[int'(wr0_addr)] = wr0_data;
    if (flush) begin
      for (int r = 0; r < NR; r++) m_pend[r] = 0;
    end else begin
      for (int r = 0; r < NR; r++) if (m_written(r)) m_pend[r] = 0;
      if (issue_en && !h && int'(issue_dest) < NR) m_pend[int'(issue_dest)] = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_addr = '0; rd_used = '0;
    wr0_en = 0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 0; wr1_addr = '0; wr1_data = '0;
    issue_en = 0; issue_dest = '0; flush = 0;
  endtask

  task automatic test_reset();
    logic [NP*DW-1:0] exp_rd;
    exp_rd = {32'd3, 32'd2, 32'd1};
    rd_addr = {4'd3, 4'd2, 4'd1};
    #1;
    checks++;
    if (rd_data !== exp_rd) begin
      errors++; $display("[TB] FAIL reset_read: got %h expected %h", rd_data, exp_rd);
    end
    checks++;
    if (pending !== '0 || hazard !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_state: got pending=%h hazard=%b expected 0/0", pending, hazard);
    end
    @(posedge clk); #1;
    rst = 1;
    issue_en = 1; issue_dest = 4'd6;
    tick();
    issue_en = 0;
    #1;
    checks++;
    if (pending !== 16'h0040) begin
      errors++; $display("[TB] FAIL reset_pre_issue: got %h expected %h", pending, 16'h0040);
    end
    wr0_en = 1; wr0_addr = 4'd5; wr0_data = 32'h55AA_55AA;
    issue_en = 1; issue_dest = 4'd7;
    #2 rst = 0;
    @(posedge clk); #1;
    model_reset();
    wr0_en = 0; issue_en = 0;
    rd_addr = {4'd3, 4'd2, 4'd5};
    #1;
    checks++;
    if (rd_data[31:0] !== 32'd5 || pending !== '0) begin
      errors++; $display("[TB] FAIL reset_midwrite: got r5=%h pending=%h expected 5/0", rd_data[31:0], pending);
    end
    rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_bypass();
    idle_inputs();
    wr0_en = 1; wr0_addr = 4'd5; wr0_data = 32'hDEAD_BEEF;
    rd_addr = {4'd0, 4'd0, 4'd5};
    #1;
    checks++;
    if (rd_data[31:0] !== 32'hDEAD_BEEF) begin
      errors++; $display("[TB] FAIL bypass_same_cycle: got %h expected deadbeef", rd_data[31:0]);
    end
    tick();
    wr0_en = 0;
    #1;
    checks++;
    if (rd_data[31:0] !== 32'hDEAD_BEEF) begin
      errors++; $display("[TB] FAIL bypass_stored: got %h expected deadbeef", rd_data[31:0]);
    end
  endtask

  task automatic test_dual_write();
    idle_inputs();
    wr0_en = 1; wr0_addr = 4'd7; wr0_data = 32'h11;
    wr1_en = 1; wr1_addr = 4'd7; wr1_data = 32'h22;
    rd_addr = {4'd0, 4'd7, 4'd0};
    #1;
    checks++;
    if (rd_data[63:32] !== 32'h11) begin
      errors++; $display("[TB] FAIL dual_bypass: got %h expected 11", rd_data[63:32]);
    end
    tick();
    wr0_en = 0; wr1_en = 0;
    #1;
    checks++;
    if (rd_data[63:32] !== 32'h11) begin
      errors++; $display("[TB] FAIL dual_stored: got %h expected 11", rd_data[63:32]);
    end
  endtask

  task automatic test_raw();
    idle_inputs();
    issue_en = 1; issue_dest = 4'd4;
    tick();
    issue_en = 0;
    rd_addr = {4'd0, 4'd0, 4'd4}; rd_used = 3'b001;
    #1;
    checks++;
    if (hazard !== 1'b1) begin
      errors++; $display("[TB] FAIL raw_hazard: got %b expected 1", hazard);
    end
    rd_used = 3'b000;
    #1;
    checks++;
    if (hazard !== 1'b0) begin
      errors++; $display("[TB] FAIL raw_unused: got %b expected 0", hazard);
    end
    rd_used = 3'b001;
    wr0_en = 1; wr0_addr = 4'd4; wr0_data = 32'h40;
    #1;
    checks++;
    if (hazard !== 1'b0 || rd_data[31:0] !== 32'h40 || pending[4] !== 1'b1) begin
      errors++; $display("[TB] FAIL raw_writeback: got hazard=%b data=%h pend4=%b expected 0/40/1",
                         hazard, rd_data[31:0], pending[4]);
    end
    tick();
    wr0_en = 0;
    #1;
    checks++;
    if (pending[4] !== 1'b0 || hazard !== 1'b0) begin
      errors++; $display("[TB] FAIL raw_cleared: got pend4=%b hazard=%b expected 0/0", pending[4], hazard);
    end
  endtask

  task automatic test_set_clear();
    idle_inputs();
    issue_en = 1; issue_dest = 4'd4;
    wr1_en = 1; wr1_addr = 4'd4; wr1_data = 32'h77;
    tick();
    wr1_en = 0;
    #1;
    checks++;
    if (pending[4] !== 1'b1) begin
      errors++; $display("[TB] FAIL setclr_set_wins: got %b expected 1", pending[4]);
    end
    checks++;
    if (hazard !== 1'b1) begin
      errors++; $display("[TB] FAIL setclr_waw: got %b expected 1", hazard);
    end
    issue_dest = 4'd8; rd_addr = {4'd0, 4'd0, 4'd4}; rd_used = 3'b001;
    tick();
    issue_en = 0; rd_used = 3'b000;
    #1;
    checks++;
    if (pending !== 16'h0010) begin
      errors++; $display("[TB] FAIL setclr_stalled_issue: got %h expected %h", pending, 16'h0010);
    end
    wr0_en = 1; wr0_addr = 4'd4; wr0_data = 32'h44;
    tick();
    wr0_en = 0;
  endtask

  task automatic test_flush();
    idle_inputs();
    issue_en = 1;
    issue_dest = 4'd1; tick();
    issue_dest = 4'd2; tick();
    issue_dest = 4'd9; tick();
    issue_en = 0;
    #1;
    checks++;
    if (pending !== 16'h0206) begin
      errors++; $display("[TB] FAIL flush_pre: got %h expected %h", pending, 16'h0206);
    end
    flush = 1; issue_en = 1; issue_dest = 4'd3;
    wr0_en = 1; wr0_addr = 4'd9; wr0_data = 32'h99;
    tick();
    flush = 0; issue_en = 0; wr0_en = 0;
    rd_addr = {4'd9, 4'd0, 4'd0};
    #1;
    checks++;
    if (pending !== '0 || rd_data[95:64] !== 32'h99) begin
      errors++; $display("[TB] FAIL flush_result: got pending=%h r9=%h expected 0/99", pending, rd_data[95:64]);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NP; k++) rd_addr[k*AW +: AW] = AW'($urandom_range(0, 9));
      rd_used    = NP'($urandom);
      wr0_en     = ($urandom_range(0, 2) == 0);
      wr0_addr   = AW'($urandom_range(0, 9));
      wr0_data   = $urandom;
      wr1_en     = ($urandom_range(0, 3) == 0);
      wr1_addr   = AW'($urandom_range(0, 9));
      wr1_data   = $urandom;
      issue_en   = ($urandom_range(0, 1) == 0);
      issue_dest = AW'($urandom_range(0, 9));
      flush      = ($urandom_range(0, 15) == 0);
      #1;
      for (int k = 0; k < NP; k++) begin
        exp = m_read(int'(rd_addr[k*AW +: AW]));
        checks++;
        if (rd_data[k*DW +: DW] !== exp) begin
          errors++; $display("[TB] FAIL rand_read%0d cycle %0d: got %h expected %h",
                             k, c, rd_data[k*DW +: DW], exp);
        end
      end
      checks++;
      if (hazard !== m_hazard()) begin
        errors++; $display("[TB] FAIL rand_hazard cycle %0d: got %b expected %b", c, hazard, m_hazard());
      end
      checks++;
      if (pending !== m_pend_vec()) begin
        errors++; $display("[TB] FAIL rand_pending cycle %0d: got %h expected %h", c, pending, m_pend_vec());
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst = 1;
    #1 rst = 0;
    test_reset();
    test_bypass();
    test_dual_write();
    test_raw();
    test_set_clear();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
